// File: rtl/chan_bus_pkg.sv
// Shared types and helpers for the I/O channel bus initiator.
package chan_bus_pkg;

  // Request operation codes as presented on req_op.
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_BAD   = 2'd3
  } op_t;

  // Bus master sequencing states; the second strobe/hold pair is used only by WRITE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_STROBE2 = 3'd4,
    ST_HOLD2   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Channel addresses of the responders on this bus (two octal digits).
  localparam logic [5:0] CH05 = 6'o05;
  localparam logic [5:0] CH06 = 6'o06;
  localparam logic [5:0] CH11 = 6'o11;
  localparam logic [5:0] CH12 = 6'o12;
  localparam logic [5:0] CH32 = 6'o32;

  // One octal digit to an 8-line one-hot-low select.
  function automatic logic [7:0] oct_sel_n(input logic [2:0] digit);
    return ~(8'h01 << digit);
  endfunction

endpackage

// File: rtl/chan_sel_decode.sv
// Registered channel-select decoder: drives XT/XB one-hot-low lines, all high when disabled.
module chan_sel_decode
  import chan_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] chan,
  output logic [7:0] xt,
  output logic [7:0] xb
);

  // Register the decoded tens/units digits, or idle levels when the bus is not in use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xt <= 8'hFF;
      xb <= 8'hFF;
    end else if (en) begin
      xt <= oct_sel_n(chan[5:3]);
      xb <= oct_sel_n(chan[2:0]);
    end else begin
      xt <= 8'hFF;
      xb <= 8'hFF;
    end
  end

endmodule

// File: rtl/chan_bus_master.sv
// I/O channel bus initiator: sequences select, strobe and write-line timing for one request.
module chan_bus_master
  import chan_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [5:0]        req_chan,
  input  logic [DATA_W-1:0] req_data,
  input  logic              gojam,
  output logic [7:0]        XT_,
  output logic [7:0]        XB_,
  output logic [DATA_W-1:0] CHWL_,
  output logic              CCHG_,
  output logic              WCHG_,
  output logic              RCHG_,
  input  logic [DATA_W-1:0] CHOR_,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data
);

  // Phase counters are 3 bits wide, so each phase must last 1..8 cycles.
  if (SETUP_CYC < 1 || SETUP_CYC > 8 || STROBE_CYC < 1 || STROBE_CYC > 8 ||
      HOLD_CYC < 1 || HOLD_CYC > 8) begin : g_bad_phase_len
    $error("chan_bus_master: SETUP_CYC/STROBE_CYC/HOLD_CYC must be within 1..8");
  end

  localparam logic [2:0] SETUP_LD  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] STROBE_LD = 3'(STROBE_CYC - 1);
  localparam logic [2:0] HOLD_LD   = 3'(HOLD_CYC - 1);

  state_t              state_reg;
  logic [2:0]          cnt_reg;
  op_t                 op_reg;
  logic [5:0]          chan_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [DATA_W-1:0]   rd_cap_reg;
  logic                ready_reg;
  logic                cchg_reg;
  logic                wchg_reg;
  logic                rchg_reg;
  logic                rsp_valid_reg;
  logic                rsp_err_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic [DATA_W-1:0]   chwl_reg;

  logic                accept;
  logic                sel_en;
  logic                wr_src;
  logic [5:0]          chan_src;
  logic [DATA_W-1:0]   data_src;

  assign accept   = (state_reg == ST_IDLE) && req_valid && ready_reg && !gojam;
  assign chan_src = (state_reg == ST_IDLE) ? req_chan : chan_reg;
  assign data_src = (state_reg == ST_IDLE) ? req_data : data_reg;
  assign wr_src   = (state_reg == ST_IDLE) ? (op_t'(req_op) == OP_WRITE) : (op_reg == OP_WRITE);

  // Decide whether the bus is still addressed in the coming cycle (selects and write lines).
  always_comb begin
    sel_en = 1'b0;
    case (state_reg)
      ST_IDLE:    sel_en = accept && (op_t'(req_op) != OP_BAD);
      ST_SETUP,
      ST_STROBE,
      ST_STROBE2: sel_en = !gojam;
      ST_HOLD:    sel_en = !gojam && !((cnt_reg == 3'd0) && (op_reg != OP_WRITE));
      ST_HOLD2:   sel_en = !gojam && (cnt_reg != 3'd0);
      default:    sel_en = 1'b0;
    endcase
  end

  chan_sel_decode u_sel (
    .clk  (clk),
    .rst  (rst),
    .en   (sel_en),
    .chan (chan_src),
    .xt   (XT_),
    .xb   (XB_)
  );

  // Write lines carry inverted data only while a WRITE is addressing the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chwl_reg <= '1;
    end else begin
      chwl_reg <= (sel_en && wr_src) ? ~data_src : '1;
    end
  end

  // Sequencer: phase counting, strobe generation, read capture and response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 3'd0;
      op_reg        <= OP_READ;
      chan_reg      <= 6'd0;
      data_reg      <= '0;
      rd_cap_reg    <= '0;
      ready_reg     <= 1'b1;
      cchg_reg      <= 1'b1;
      wchg_reg      <= 1'b1;
      rchg_reg      <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      cchg_reg      <= 1'b1;
      wchg_reg      <= 1'b1;
      rchg_reg      <= 1'b1;
      if (gojam && state_reg != ST_IDLE && state_reg != ST_DONE) begin
        // Abort: strobes already default high; keep the previous read data.
        state_reg     <= ST_DONE;
        rsp_valid_reg <= 1'b1;
        rsp_err_reg   <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            ready_reg <= !gojam;
            if (accept) begin
              op_reg    <= op_t'(req_op);
              chan_reg  <= req_chan;
              data_reg  <= req_data;
              ready_reg <= 1'b0;
              if (op_t'(req_op) == OP_BAD) begin
                state_reg     <= ST_DONE;
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= 1'b1;
                rsp_data_reg  <= '0;
              end else begin
                state_reg <= ST_SETUP;
                cnt_reg   <= SETUP_LD;
              end
            end
          end
          ST_SETUP: begin
            if (cnt_reg == 3'd0) begin
              state_reg <= ST_STROBE;
              cnt_reg   <= STROBE_LD;
              if (op_reg == OP_READ) rchg_reg <= 1'b0;
              else                   cchg_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 3'd1;
            end
          end
          ST_STROBE: begin
            if (cnt_reg == 3'd0) begin
              if (op_reg == OP_READ) rd_cap_reg <= ~CHOR_;
              state_reg <= ST_HOLD;
              cnt_reg   <= HOLD_LD;
            end else begin
              cnt_reg <= cnt_reg - 3'd1;
              if (op_reg == OP_READ) rchg_reg <= 1'b0;
              else                   cchg_reg <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (cnt_reg == 3'd0) begin
              if (op_reg == OP_WRITE) begin
                state_reg <= ST_STROBE2;
                cnt_reg   <= STROBE_LD;
                wchg_reg  <= 1'b0;
              end else begin
                state_reg     <= ST_DONE;
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= 1'b0;
                rsp_data_reg  <= (op_reg == OP_READ) ? rd_cap_reg : '0;
              end
            end else begin
              cnt_reg <= cnt_reg - 3'd1;
            end
          end
          ST_STROBE2: begin
            if (cnt_reg == 3'd0) begin
              state_reg <= ST_HOLD2;
              cnt_reg   <= HOLD_LD;
            end else begin
              cnt_reg  <= cnt_reg - 3'd1;
              wchg_reg <= 1'b0;
            end
          end
          ST_HOLD2: begin
            if (cnt_reg == 3'd0) begin
              state_reg     <= ST_DONE;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b0;
              rsp_data_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg - 3'd1;
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
            ready_reg <= !gojam;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_ready = ready_reg;
  assign CHWL_     = chwl_reg;
  assign CCHG_     = cchg_reg;
  assign WCHG_     = wchg_reg;
  assign RCHG_     = rchg_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = rsp_data_reg;

endmodule
